// File: rtl/hdmi_video_timing_pkg.sv
// Shared definitions for the HDMI raster sequencer.
//  - timing_state_t : sequencer FSM states
//  - VGA640_* / HD720_* : standard 640x480@60 and 1280x720@60 timing presets
//  - sync_level()    : maps a logical "sync active" flag to the pin level
package hdmi_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } timing_state_t;

  // 640x480@60 (25.175 MHz pixel clock), negative syncs
  localparam int VGA640_H_ACTIVE  = 640;
  localparam int VGA640_H_FP      = 16;
  localparam int VGA640_H_SYNC    = 96;
  localparam int VGA640_H_BP      = 48;
  localparam int VGA640_V_ACTIVE  = 480;
  localparam int VGA640_V_FP      = 10;
  localparam int VGA640_V_SYNC    = 2;
  localparam int VGA640_V_BP      = 33;
  localparam bit VGA640_HSYNC_POL = 1'b0;
  localparam bit VGA640_VSYNC_POL = 1'b0;

  // 1280x720@60 (74.25 MHz pixel clock), positive syncs
  localparam int HD720_H_ACTIVE  = 1280;
  localparam int HD720_H_FP      = 110;
  localparam int HD720_H_SYNC    = 40;
  localparam int HD720_H_BP      = 220;
  localparam int HD720_V_ACTIVE  = 720;
  localparam int HD720_V_FP      = 5;
  localparam int HD720_V_SYNC    = 5;
  localparam int HD720_V_BP      = 20;
  localparam bit HD720_HSYNC_POL = 1'b1;
  localparam bit HD720_VSYNC_POL = 1'b1;

  // pol=1: sync pulse is driven high; pol=0: sync pulse is driven low.
  function automatic logic sync_level(input logic pol, input logic active);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/hdmi_video_timing_if.sv
// Video timing bundle between the raster sequencer, the pixel source and
// the transmitter.
//  enable      : run request into the sequencer
//  req_valid   : pixel fetch request for (req_x, req_y)
//  frame_start : one-clock pulse alongside the first request of a frame
//  de/hsync/vsync/ctl : transmitter timing and control
//  busy        : sequencer is not idle
//  dbg_state   : sequencer FSM state, for observation only
//
// Handshake: req_valid is a strobe with no back-pressure (there is no
// ready). Whoever sees req_valid=1 must present the pixel for
// (req_x, req_y) exactly one clock later, which is the clock on which de=1
// for that pixel. req_x/req_y keep their last value while req_valid=0.
interface hdmi_video_timing_if #(
  parameter int XW = 10,
  parameter int YW = 9
);
  import hdmi_timing_pkg::*;

  logic          enable;
  logic          req_valid;
  logic [XW-1:0] req_x;
  logic [YW-1:0] req_y;
  logic          frame_start;
  logic          de;
  logic          hsync;
  logic          vsync;
  logic [3:0]    ctl;
  logic          busy;
  timing_state_t dbg_state;

  // Sequencer side
  modport master (
    input  enable,
    output req_valid, req_x, req_y, frame_start,
    output de, hsync, vsync, ctl, busy, dbg_state
  );

  // Frame source / transmitter side
  modport slave (
    output enable,
    input  req_valid, req_x, req_y, frame_start,
    input  de, hsync, vsync, ctl, busy, dbg_state
  );

endinterface

// File: rtl/hdmi_video_timing_axis_counter.sv
// One raster axis (horizontal in clocks or vertical in lines).
// Layout of one period: ACTIVE, then FP, then SYNC, then BP.
//  clk, rst  : clock, synchronous active-high reset
//  clr       : hold the counter at 0 (wins over step)
//  step      : advance by one, wrapping after the last position
//  cnt       : current position
//  in_active : cnt is in the active region
//  in_sync   : cnt is in the sync region
//  last      : cnt is the final position of the period
module timing_axis_counter #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int CW     = $clog2(ACTIVE + FP + SYNC + BP)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          step,
  output logic [CW-1:0] cnt,
  output logic          in_active,
  output logic          in_sync,
  output logic          last
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CW-1:0] ACTIVE_END = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);
  localparam logic [CW-1:0] LAST_CNT   = CW'(TOTAL - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

  assign in_active = (cnt < ACTIVE_END);
  assign in_sync   = (cnt >= SYNC_START) && (cnt < SYNC_END);
  assign last      = (cnt == LAST_CNT);

endmodule

// File: rtl/hdmi_video_timing.sv
// Raster sequencer for the HDMI video path (pixel_clk domain).
// Runs horizontal/vertical counters and produces:
//  stage 1: req_valid/req_x/req_y/frame_start (pixel fetch request)
//  stage 2: de/hsync/vsync, one clock after stage 1, so a pixel returned
//           one clock after its request lines up with de.
// Ports:
//  pixel_clk : the only clock
//  rst       : synchronous reset, active high, overrides enable
//  vt        : hdmi_video_timing_if master (enable in; timing/requests out)
module hdmi_video_timing
  import hdmi_timing_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic                pixel_clk,
  input  logic                rst,
  hdmi_video_timing_if.master vt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_param_check
    $fatal(1, "hdmi_video_timing: every timing parameter must be >= 1");
  end

  timing_state_t state, state_next;
  logic          running;

  logic [HW-1:0] h_cnt;
  logic          h_active, h_sync, h_last;
  logic [VW-1:0] v_cnt;
  logic          v_active, v_sync, v_last;

  // Stage-1 sync decode, carried into stage 2 alongside req_valid
  logic s1_hs, s1_vs;

  assign running = (state != ST_IDLE);

  // Counters sit at 0 whenever idle, so a start always begins at (0,0).
  timing_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(HW)
  ) u_h_axis (
    .clk(pixel_clk), .rst(rst), .clr(!running), .step(running),
    .cnt(h_cnt), .in_active(h_active), .in_sync(h_sync), .last(h_last)
  );

  timing_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(VW)
  ) u_v_axis (
    .clk(pixel_clk), .rst(rst), .clr(!running), .step(running && h_last),
    .cnt(v_cnt), .in_active(v_active), .in_sync(v_sync), .last(v_last)
  );

  // FSM state register
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state. STOPPING keeps the raster going so the current frame
  // is never cut short; re-enabling there resumes without a gap.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:     if (vt.enable) state_next = ST_RUN;
      ST_RUN:      if (!vt.enable) state_next = ST_STOPPING;
      ST_STOPPING: begin
        if (vt.enable) begin
          state_next = ST_RUN;
        end else if (h_last && v_last) begin
          state_next = ST_IDLE;
        end
      end
      default:     state_next = ST_IDLE;
    endcase
  end

  // Stage 1: fetch request. Inputs are forced inactive while idle.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      vt.req_valid   <= 1'b0;
      vt.req_x       <= '0;
      vt.req_y       <= '0;
      vt.frame_start <= 1'b0;
      s1_hs          <= 1'b0;
      s1_vs          <= 1'b0;
    end else if (running) begin
      vt.req_valid <= h_active && v_active;
      if (h_active && v_active) begin
        vt.req_x <= h_cnt[XW-1:0];
        vt.req_y <= v_cnt[YW-1:0];
      end
      vt.frame_start <= (h_cnt == '0) && (v_cnt == '0);
      s1_hs          <= h_sync;
      s1_vs          <= v_sync;
    end else begin
      vt.req_valid   <= 1'b0;
      vt.frame_start <= 1'b0;
      s1_hs          <= 1'b0;
      s1_vs          <= 1'b0;
    end
  end

  // Stage 2: transmitter timing, one clock behind the request
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      vt.de    <= 1'b0;
      vt.hsync <= sync_level(HSYNC_POL, 1'b0);
      vt.vsync <= sync_level(VSYNC_POL, 1'b0);
    end else begin
      vt.de    <= vt.req_valid;
      vt.hsync <= sync_level(HSYNC_POL, s1_hs);
      vt.vsync <= sync_level(VSYNC_POL, s1_vs);
    end
  end

  assign vt.ctl       = 4'b0000;
  assign vt.busy      = running;
  assign vt.dbg_state = state;

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Bench for hdmi_video_timing with a tiny raster: H 4/1/2/1 (8 clocks per
// line), V 3/1/1/1 (6 lines), both syncs active high, 48 clocks per frame.
// The reference model tracks the raster as a single linear position within
// the frame and derives x/y and the active/sync windows arithmetically.
module tb_hdmi_video_timing;
  import hdmi_timing_pkg::*;

  localparam int H_ACTIVE = 4, H_FP = 1, H_SYNC = 2, H_BP = 1;
  localparam int V_ACTIVE = 3, V_FP = 1, V_SYNC = 1, V_BP = 1;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int F_TOTAL  = H_TOTAL * V_TOTAL;

  // ---------------- clock / reset ----------------
  logic pixel_clk = 1'b0;
  logic rst       = 1'b1;
  always #5 pixel_clk = ~pixel_clk;

  hdmi_video_timing_if #(.XW(2), .YW(2)) vt ();

  hdmi_video_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut (
    .pixel_clk(pixel_clk),
    .rst(rst),
    .vt(vt)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Decoded position per pipeline stage: {valid, frame_start, hs, vs}.
  // exp_q[1] is what stage 1 shows now, exp_q[0] what stage 2 shows.
  logic [3:0] exp_q[$];
  int         m_mode;   // 0 = idle, 1 = run, 2 = stopping
  int         m_pos;    // linear raster position within the frame
  logic [1:0] m_x, m_y; // last requested coordinate

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
  endtask

  function automatic logic [3:0] decode(input int pos);
    int x, y;
    x = pos % H_TOTAL;
    y = pos / H_TOTAL;
    decode = {(x < H_ACTIVE) && (y < V_ACTIVE),
              (pos == 0),
              (x >= H_ACTIVE + H_FP) && (x < H_ACTIVE + H_FP + H_SYNC),
              (y >= V_ACTIVE + V_FP) && (y < V_ACTIVE + V_FP + V_SYNC)};
  endfunction

  task automatic model_edge();
    logic [3:0] d;
    int old_mode;
    if (rst) begin
      m_mode = 0;
      m_pos  = 0;
      m_x    = 2'd0;
      m_y    = 2'd0;
      exp_q  = {4'b0000, 4'b0000};
    end else begin
      old_mode = m_mode;
      d = (old_mode != 0) ? decode(m_pos) : 4'b0000;
      if (d[3]) begin
        m_x = 2'(m_pos % H_TOTAL);
        m_y = 2'(m_pos / H_TOTAL);
      end
      exp_q.push_back(d);
      void'(exp_q.pop_front());
      case (old_mode)
        0: if (vt.enable) m_mode = 1;
        1: if (!vt.enable) m_mode = 2;
        default: begin
          if (vt.enable) m_mode = 1;
          else if (m_pos == F_TOTAL - 1) m_mode = 0;
        end
      endcase
      if (old_mode != 0) m_pos = (m_pos + 1) % F_TOTAL;
    end
  endtask

  task automatic check_outputs();
    logic [3:0] s1, s2;
    s1 = exp_q[1];
    s2 = exp_q[0];
    check_eq("req_valid",   vt.req_valid,   s1[3]);
    check_eq("frame_start", vt.frame_start, s1[2]);
    check_eq("req_x",       vt.req_x,       m_x);
    check_eq("req_y",       vt.req_y,       m_y);
    check_eq("de",          vt.de,          s2[3]);
    check_eq("hsync",       vt.hsync,       s2[1]);
    check_eq("vsync",       vt.vsync,       s2[0]);
    check_eq("busy",        vt.busy,        m_mode != 0);
    check_eq("ctl",         vt.ctl,         0);
  endtask

  // ---------------- driver ----------------
  // One clock: model follows the edge, outputs are checked on the falling edge.
  task automatic step();
    @(posedge pixel_clk);
    model_edge();
    @(negedge pixel_clk);
    check_outputs();
    cyc++;
  endtask

  initial begin
    int last_fs, n_fs, n, p;
    int cnt_de, cnt_hs, cnt_vs, cnt_fs;
    exp_q = {4'b0000, 4'b0000};
    m_mode = 0; m_pos = 0; m_x = 2'd0; m_y = 2'd0;
    vt.enable = 1'b1;
    rst = 1'b1;

    // Reset held with enable high
    for (int i = 0; i < 10; i++) step();

    // Start: request at (0,0) one clock after the enabling edge, de after two
    rst = 1'b0;
    step();
    check_eq("start_req_early", vt.req_valid, 0);
    step();
    check_eq("start_req_valid", vt.req_valid, 1);
    check_eq("start_frame_start", vt.frame_start, 1);
    check_eq("start_de_early", vt.de, 0);
    step();
    check_eq("start_de", vt.de, 1);

    // Steady run: frame_start period
    last_fs = cyc - 1;
    n_fs = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (vt.frame_start) begin
        check_eq("fs_period", cyc - last_fs, F_TOTAL);
        last_fs = cyc;
        n_fs++;
      end
    end
    check_eq("fs_count", n_fs, 2);

    // Any 48 consecutive clocks of steady run hold one full frame
    cnt_de = 0; cnt_hs = 0; cnt_vs = 0; cnt_fs = 0;
    for (int i = 0; i < F_TOTAL; i++) begin
      step();
      cnt_de += int'(vt.de);
      cnt_hs += int'(vt.hsync);
      cnt_vs += int'(vt.vsync);
      cnt_fs += int'(vt.frame_start);
    end
    check_eq("frame_de_clocks", cnt_de, H_ACTIVE * V_ACTIVE);
    check_eq("frame_hsync_clocks", cnt_hs, H_SYNC * V_TOTAL);
    check_eq("frame_vsync_clocks", cnt_vs, V_SYNC * H_TOTAL);
    check_eq("frame_fs_pulses", cnt_fs, 1);

    // Stop during line 1: the frame runs to its end before going idle
    n = 0;
    while (!(m_pos >= H_TOTAL && m_pos < 2 * H_TOTAL) && n < 100) begin
      step();
      n++;
    end
    p = m_pos;
    vt.enable = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (vt.busy && n < 200);
    check_eq("stop_drain", n, F_TOTAL - p);
    step();
    step();
    check_eq("idle_de", vt.de, 0);

    // Second run: re-enable during stopping leaves no gap in the raster
    vt.enable = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!vt.frame_start && n < 10);
    check_eq("rerun_fs", vt.frame_start, 1);
    last_fs = cyc;
    for (int i = 0; i < 20; i++) step();
    vt.enable = 1'b0;
    for (int i = 0; i < 5; i++) step();
    vt.enable = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!vt.frame_start && n < 60);
    check_eq("resume_no_gap", cyc - last_fs, F_TOTAL);

    // One-clock reset pulse while de is high
    n = 0;
    while (!vt.de && n < 100) begin
      step();
      n++;
    end
    check_eq("wait_de", vt.de, 1);
    rst = 1'b1;
    step();
    check_eq("rst_pulse_de", vt.de, 0);
    check_eq("rst_pulse_busy", vt.busy, 0);
    rst = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!vt.frame_start && n < 60);
    check_eq("restart_fs", vt.frame_start, 1);
    check_eq("restart_x", vt.req_x, 0);
    check_eq("restart_y", vt.req_y, 0);

    // Random enable toggling with occasional reset
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) vt.enable = ~vt.enable;
      rst = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
